exec_alu_unit: RTL and testbench
================================

// Module: exec_alu_unit
// PURPOSE
//  Execute-stage datapath slice of the single-cycle MIPS core: PC+4 incrementer,
//  ALU second-operand mux (register vs sign-extended immediate), and 32-bit ALU.
//  Registers the PC+4, result and zero outputs for branch/jump/write-back logic.
//  Sits between reg_file/sign_extend/alucontrol and data_memory/write_back_mux.
// PARAMETERS
//  WIDTH     32  datapath width (only 32 is supported)
//  PC_STEP   4   PC increment in bytes
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  pc_in      in   32     current PC
//  rs_data    in   32     ALU operand A (reg_file read 1)
//  rt_data    in   32     mux input 0 (reg_file read 2)
//  imm_ext    in   32     mux input 1 (sign-extended immediate)
//  alu_src    in   1      0: B=rt_data, 1: B=imm_ext
//  alu_ctrl   in   4      operation select
//  alu_b      out  32     mux output, combinational (debug/store data path)
//  pc_plus4   out  32     registered pc_in+PC_STEP
//  alu_result out  32     registered ALU result
//  alu_zero   out  1      registered flag, (result == 0)
//  alu_ovf    out  1      registered signed overflow (only with ALU_OVF_EN)
// BEHAVIOUR
//  - One clock, clk; rst is synchronous, active-high. On a rising edge with rst=1:
//    pc_plus4=0, alu_result=0, alu_zero=0, alu_ovf=0. rst has priority.
//  - Otherwise every rising edge captures the new values. No stall/enable; latency
//    is 1 cycle from inputs to registered outputs.
//  - alu_b = alu_src ? imm_ext : rt_data (no latency).
//  - pc_plus4 = pc_in + 4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
//  - alu_ctrl codes (A=rs_data, B=alu_b):
//    0000 AND  A&B          0001 OR   A|B         0010 ADD  A+B (wraps)
//    0110 SUB  A-B (wraps)  0111 SLT  signed A<B ? 1 : 0
//    1100 NOR  ~(A|B)       0011 LUI  {B[15:0],16'h0}
//    1010 BNE  (A==B) ? 1 : 0, so zero=1 iff A!=B
//    1011 BGEZ A[31] ? 1 : 0, so zero=1 iff A>=0 (B ignored)
//    other     result=0 (zero=1)
//  - alu_zero = (result == 32'h0) for every code. BEQ uses SUB.
//  - SLT compares signed: 0x80000000 < 0x00000001 -> 1.
//  - ADD/SUB never trap; overflow only reported via alu_ovf when enabled.
// CONFIGURATION
//  ALU_OVF_EN defined: alu_ovf port exists. It is set on ADD when A, B share a
//    sign and the result sign differs. It is set on SUB when A, B differ in sign
//    and the result sign differs from A. It is 0 for every other code.
//  ALU_OVF_EN undefined: alu_ovf port is absent and there is no overflow logic.
//    All other behaviour is identical.
// TESTING
//  1. rst=1 for 1 edge with any inputs -> pc_plus4=0, alu_result=0, alu_zero=0.
//  2. pc_in=0x0 -> pc_plus4=0x4 next edge; pc_in=0xFFFFFFFC -> pc_plus4=0x0.
//  3. ADD: A=5, rt=7, alu_src=0 -> result 12, zero 0.
//     alu_src=1, imm=0xFFFFFFFF -> result 4, and alu_b=0xFFFFFFFF immediately.
//  4. SUB: A=9, rt=9 -> result 0, zero 1. SLT: A=0xFFFFFFFE, B=1 -> result 1.
//     NOR: A=0, B=0 -> result 0xFFFFFFFF.
//  5. LUI: imm=0x00001234 -> result 0x12340000. BNE: A=3, B=3 -> zero 0.
//     BGEZ: A=0x80000000 -> zero 0; A=0 -> zero 1.
//  6. With ALU_OVF_EN: ADD 0x7FFFFFFF + 1 -> result 0x80000000, alu_ovf=1.
//     Then unknown code 1111 -> result 0, zero 1, ovf 0.

Source files
------------

// File: rtl/exec_alu_unit.sv
// Execute-stage slice: PC incrementer, ALU operand-B mux and 32-bit ALU with registered outputs.
// Optional signed-overflow flag and port are enabled by defining ALU_OVF_EN.
module exec_alu_unit #(
    parameter int WIDTH   = 32,
    parameter int PC_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic             alu_src,
    input  logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_b,
`ifdef ALU_OVF_EN
    output logic             alu_ovf,
`endif
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_zero
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_LUI  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BGEZ = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] pc_plus4_d, pc_plus4_q;
    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;

    assign a     = rs_data;
    assign alu_b = alu_src ? imm_ext : rt_data;
    assign sum   = a + alu_b;
    assign diff  = a - alu_b;

    always_comb begin
        pc_plus4_d = pc_in + WIDTH'(PC_STEP);
        result_d   = '0;
        unique case (alu_ctrl)
            OP_AND:  result_d = a & alu_b;
            OP_OR:   result_d = a | alu_b;
            OP_ADD:  result_d = sum;
            OP_SUB:  result_d = diff;
            OP_SLT:  result_d = ($signed(a) < $signed(alu_b)) ? WIDTH'(1) : '0;
            OP_NOR:  result_d = ~(a | alu_b);
            OP_LUI:  result_d = {alu_b[15:0], 16'h0000};
            // Branch helpers invert the sense so that zero=1 means "branch taken".
            OP_BNE:  result_d = (a == alu_b) ? WIDTH'(1) : '0;
            OP_BGEZ: result_d = a[WIDTH-1] ? WIDTH'(1) : '0;
            default: result_d = '0;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_plus4_q <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
        end else begin
            pc_plus4_q <= pc_plus4_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
        end
    end

    assign pc_plus4   = pc_plus4_q;
    assign alu_result = result_q;
    assign alu_zero   = zero_q;

`ifdef ALU_OVF_EN
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = 1'b0;
        if (alu_ctrl == OP_ADD)
            ovf_d = (a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        else if (alu_ctrl == OP_SUB)
            ovf_d = (a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign alu_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_exec_alu_unit.sv
// Directed vector bench for exec_alu_unit; overflow checks compile in only with ALU_OVF_EN.
module tb_exec_alu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, rs_data, rt_data, imm_ext;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_b, pc_plus4, alu_result;
    logic        alu_zero;
`ifdef ALU_OVF_EN
    logic        alu_ovf;
`endif

    always #5 clk = ~clk;

    exec_alu_unit dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .imm_ext    (imm_ext),
        .alu_src    (alu_src),
        .alu_ctrl   (alu_ctrl),
        .alu_b      (alu_b),
`ifdef ALU_OVF_EN
        .alu_ovf    (alu_ovf),
`endif
        .pc_plus4   (pc_plus4),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] rt;
        logic [31:0] imm;
        logic        src;
        logic [3:0]  ctrl;
        logic [31:0] exp_b;
        logic [31:0] exp_pc;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_ovf;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];
    int n_vec  = 0;
    int n_chk  = 0;
    int n_err  = 0;

    function automatic vec_t mk(logic r, logic [31:0] pc, logic [31:0] a, logic [31:0] rt,
                                logic [31:0] imm, logic src, logic [3:0] ctrl,
                                logic [31:0] eb, logic [31:0] epc, logic [31:0] eres,
                                logic ez, logic eo);
        vec_t v;
        v.rst = r; v.pc = pc; v.a = a; v.rt = rt; v.imm = imm; v.src = src; v.ctrl = ctrl;
        v.exp_b = eb; v.exp_pc = epc; v.exp_res = eres; v.exp_zero = ez; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic [31:0] pc, logic [31:0] a, logic [31:0] rt,
                         logic [31:0] imm, logic src, logic [3:0] ctrl);
        rst = r; pc_in = pc; rs_data = a; rt_data = rt; imm_ext = imm;
        alu_src = src; alu_ctrl = ctrl;
    endtask

    // Called 1 time unit after a rising edge; leaves time 1 unit after the next edge.
    task automatic apply(int idx, vec_t v);
        drive(v.rst, v.pc, v.a, v.rt, v.imm, v.src, v.ctrl);
        #1;
        chk32($sformatf("v%0d alu_b", idx), alu_b, v.exp_b);
        @(posedge clk);
        #1;
        n_vec++;
        chk32($sformatf("v%0d pc_plus4", idx), pc_plus4, v.exp_pc);
        chk32($sformatf("v%0d alu_result", idx), alu_result, v.exp_res);
        chk1($sformatf("v%0d alu_zero", idx), alu_zero, v.exp_zero);
`ifdef ALU_OVF_EN
        chk1($sformatf("v%0d alu_ovf", idx), alu_ovf, v.exp_ovf);
`endif
        $display("vec %0d: rst=%b ctrl=%b a=%08h b=%08h -> pc4=%08h res=%08h zero=%b",
                 idx, v.rst, v.ctrl, v.a, alu_b, pc_plus4, alu_result, alu_zero);
    endtask

    initial begin
        //              rst pc            a             rt            imm           src ctrl     exp_b         exp_pc        exp_res       z  o
        vecs[0]  = mk(1, 32'h00000100, 32'd5,        32'd7,        32'h0,        0, 4'b0010, 32'd7,        32'h0,        32'h0,        0, 0);
        vecs[1]  = mk(0, 32'h00000000, 32'd5,        32'd7,        32'h0,        0, 4'b0010, 32'd7,        32'h4,        32'd12,       0, 0);
        vecs[2]  = mk(0, 32'hFFFFFFFC, 32'd5,        32'd7,        32'hFFFFFFFF, 1, 4'b0010, 32'hFFFFFFFF, 32'h0,        32'd4,        0, 0);
        vecs[3]  = mk(0, 32'h00001000, 32'd9,        32'd9,        32'h0,        0, 4'b0110, 32'd9,        32'h00001004, 32'h0,        1, 0);
        vecs[4]  = mk(0, 32'h00001004, 32'hFFFFFFFE, 32'd1,        32'h0,        0, 4'b0111, 32'd1,        32'h00001008, 32'd1,        0, 0);
        vecs[5]  = mk(0, 32'h00001008, 32'h80000000, 32'd1,        32'h0,        0, 4'b0111, 32'd1,        32'h0000100C, 32'd1,        0, 0);
        vecs[6]  = mk(0, 32'h0000100C, 32'd1,        32'h80000000, 32'h0,        0, 4'b0111, 32'h80000000, 32'h00001010, 32'h0,        1, 0);
        vecs[7]  = mk(0, 32'h00001010, 32'h0,        32'h0,        32'h0,        0, 4'b1100, 32'h0,        32'h00001014, 32'hFFFFFFFF, 0, 0);
        vecs[8]  = mk(0, 32'h00001014, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        0, 4'b0000, 32'hFF00FF00, 32'h00001018, 32'hF000F000, 0, 0);
        vecs[9]  = mk(0, 32'h00001018, 32'h0F0F0000, 32'h0,        32'h000000F0, 1, 4'b0001, 32'h000000F0, 32'h0000101C, 32'h0F0F00F0, 0, 0);
        vecs[10] = mk(0, 32'h0000101C, 32'hDEADBEEF, 32'h0,        32'h00001234, 1, 4'b0011, 32'h00001234, 32'h00001020, 32'h12340000, 0, 0);
        vecs[11] = mk(0, 32'h00001020, 32'd3,        32'd3,        32'h0,        0, 4'b1010, 32'd3,        32'h00001024, 32'd1,        0, 0);
        vecs[12] = mk(0, 32'h00001024, 32'd3,        32'd4,        32'h0,        0, 4'b1010, 32'd4,        32'h00001028, 32'h0,        1, 0);
        vecs[13] = mk(0, 32'h00001028, 32'h80000000, 32'd5,        32'h0,        0, 4'b1011, 32'd5,        32'h0000102C, 32'd1,        0, 0);
        vecs[14] = mk(0, 32'h0000102C, 32'h0,        32'd5,        32'h0,        0, 4'b1011, 32'd5,        32'h00001030, 32'h0,        1, 0);
        vecs[15] = mk(0, 32'h00001030, 32'h7FFFFFFF, 32'd1,        32'h0,        0, 4'b0010, 32'd1,        32'h00001034, 32'h80000000, 0, 1);
        vecs[16] = mk(0, 32'h00001034, 32'h7FFFFFFF, 32'd1,        32'h0,        0, 4'b1111, 32'd1,        32'h00001038, 32'h0,        1, 0);
        vecs[17] = mk(0, 32'h00001038, 32'h80000000, 32'd1,        32'h0,        0, 4'b0110, 32'd1,        32'h0000103C, 32'h7FFFFFFF, 0, 1);
        vecs[18] = mk(0, 32'h0000103C, 32'd5,        32'd7,        32'h0,        0, 4'b0110, 32'd7,        32'h00001040, 32'hFFFFFFFE, 0, 0);
        vecs[19] = mk(0, 32'h00001040, 32'h80000000, 32'h80000000, 32'h0,        0, 4'b0010, 32'h80000000, 32'h00001044, 32'h0,        1, 1);
        vecs[20] = mk(1, 32'h00001044, 32'h7FFFFFFF, 32'd1,        32'h0,        0, 4'b0010, 32'd1,        32'h0,        32'h0,        0, 0);

        drive(1, 32'h0, 32'h0, 32'h0, 32'h0, 0, 4'b0000);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) apply(i, vecs[i]);

        // One-cycle latency: new inputs must not show on the registered outputs before the edge.
        drive(0, 32'h00002000, 32'd2, 32'd3, 32'h0, 0, 4'b0010);
        #2;
        chk32("latency pre-edge result", alu_result, 32'h0);
        chk32("latency pre-edge pc_plus4", pc_plus4, 32'h0);
        @(posedge clk);
        #1;
        n_vec++;
        chk32("latency post-edge result", alu_result, 32'd5);
        chk32("latency post-edge pc_plus4", pc_plus4, 32'h00002004);
        $display("seq latency: res=%08h pc4=%08h", alu_result, pc_plus4);

        // Outputs hold-free: a second edge with changed operands updates immediately.
        drive(0, 32'h00002004, 32'd2, 32'd2, 32'h0, 0, 4'b0110);
        @(posedge clk);
        #1;
        n_vec++;
        chk32("back-to-back result", alu_result, 32'h0);
        chk1("back-to-back zero", alu_zero, 1'b1);
        $display("seq back-to-back: res=%08h zero=%b", alu_result, alu_zero);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
